// File: rtl/wt_mem_arbiter.sv
// wt_mem_arbiter: round-robin arbiter between instruction fetch and data cache onto one tagged memory port
// Ports:
//   clk_i, rst_i                          clock, asynchronous active-high reset
//   ifu_req_i/ifu_addr_i/ifu_gnt_o        fetch read request and combinational grant
//   dc_req_i/dc_we_i/dc_addr_i/dc_wdata_i/dc_gnt_o  data cache load/store request and grant
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_tid_o  registered memory request, held until mem_gnt_i
//   mem_gnt_i                             memory accepts the held request
//   mem_rvalid_i/mem_rtid_i/mem_rdata_i   tagged response
//   ifu_rvalid_o/dc_rvalid_o/rdata_o      response routed to the TID owner
//   outst_stores_o                        stores issued but not yet acknowledged
//   err_o                                 sticky: response seen for an unallocated TID
module wt_mem_arbiter #(
    parameter int AddrWidth            = 64,
    parameter int DataWidth            = 64,
    parameter int MemTidWidth          = 2,
    parameter int MaxOutstandingStores = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ifu_req_i,
    input  logic [AddrWidth-1:0]   ifu_addr_i,
    output logic                   ifu_gnt_o,
    input  logic                   dc_req_i,
    input  logic                   dc_we_i,
    input  logic [AddrWidth-1:0]   dc_addr_i,
    input  logic [DataWidth-1:0]   dc_wdata_i,
    output logic                   dc_gnt_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [MemTidWidth-1:0] mem_tid_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [MemTidWidth-1:0] mem_rtid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    output logic                   ifu_rvalid_o,
    output logic                   dc_rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [3:0]             outst_stores_o,
    output logic                   err_o
);
    localparam int NumTid = 2 ** MemTidWidth;
    localparam logic [3:0] StoreCap = 4'(MaxOutstandingStores);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 r_state;
    logic [NumTid-1:0]      r_used;
    logic [NumTid-1:0]      r_own_dc;
    logic [NumTid-1:0]      r_is_st;
    logic                   r_ptr_dc;
    logic [3:0]             r_stores;
    logic                   r_err;
    logic                   r_mem_we;
    logic [AddrWidth-1:0]   r_mem_addr;
    logic [DataWidth-1:0]   r_mem_wdata;
    logic [MemTidWidth-1:0] r_mem_tid;

    logic                   w_free_any;
    logic [MemTidWidth-1:0] w_free_tid;
    logic                   w_ifu_el;
    logic                   w_dc_el;
    logic                   w_pick_dc;
    logic                   w_accept;
    logic                   w_st_inc;
    logic                   w_st_dec;
    logic                   w_rsp_ok;
    logic [NumTid-1:0]      w_alloc;
    logic [NumTid-1:0]      w_rel;

    // Lowest free TID from the bitmap as registered; a TID released this cycle is not visible until next cycle.
    always_comb begin
        w_free_any = 1'b0;
        w_free_tid = '0;
        for (int i = NumTid - 1; i >= 0; i--) begin
            if (!r_used[i]) begin
                w_free_any = 1'b1;
                w_free_tid = MemTidWidth'(i);
            end
        end
    end

    assign w_ifu_el  = ifu_req_i && w_free_any;
    assign w_dc_el   = dc_req_i && w_free_any && (!dc_we_i || r_stores < StoreCap);
    assign w_pick_dc = w_dc_el && (!w_ifu_el || r_ptr_dc);
    // Two-state FSM: the slot is free when idle or when the held request is taken this cycle.
    assign w_accept  = (r_state == IDLE || mem_gnt_i) && (w_ifu_el || w_dc_el);
    assign ifu_gnt_o = w_accept && !w_pick_dc;
    assign dc_gnt_o  = w_accept && w_pick_dc;
    assign w_st_inc  = dc_gnt_o && dc_we_i;

    assign w_rsp_ok     = mem_rvalid_i && r_used[mem_rtid_i];
    assign w_st_dec     = w_rsp_ok && r_is_st[mem_rtid_i];
    assign ifu_rvalid_o = w_rsp_ok && !r_own_dc[mem_rtid_i];
    assign dc_rvalid_o  = w_rsp_ok && r_own_dc[mem_rtid_i];
    assign rdata_o      = w_rsp_ok ? mem_rdata_i : '0;

    assign w_alloc = w_accept ? NumTid'(1) << w_free_tid : '0;
    assign w_rel   = w_rsp_ok ? NumTid'(1) << mem_rtid_i : '0;

    assign mem_req_o      = (r_state == BUSY);
    assign mem_we_o       = r_mem_we;
    assign mem_addr_o     = r_mem_addr;
    assign mem_wdata_o    = r_mem_wdata;
    assign mem_tid_o      = r_mem_tid;
    assign outst_stores_o = r_stores;
    assign err_o          = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_used      <= '0;
            r_own_dc    <= '0;
            r_is_st     <= '0;
            r_ptr_dc    <= 1'b0;
            r_stores    <= '0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_tid   <= '0;
        end else begin
            if (w_accept) begin
                r_state            <= BUSY;
                r_mem_addr         <= w_pick_dc ? dc_addr_i : ifu_addr_i;
                r_mem_wdata        <= w_pick_dc ? dc_wdata_i : '0;
                r_mem_we           <= w_st_inc;
                r_mem_tid          <= w_free_tid;
                r_ptr_dc           <= !w_pick_dc;
                r_own_dc[w_free_tid] <= w_pick_dc;
                r_is_st[w_free_tid]  <= w_st_inc;
            end else if (mem_gnt_i) begin
                r_state <= IDLE;
            end
            r_used   <= (r_used & ~w_rel) | w_alloc;
            r_stores <= (w_st_inc && !w_st_dec) ? r_stores + 4'd1 :
                        (!w_st_inc && w_st_dec) ? r_stores - 4'd1 : r_stores;
            if (mem_rvalid_i && !r_used[mem_rtid_i])
                r_err <= 1'b1;
        end
    end
endmodule
